sprite_line_scheduler: RTL and testbench



---
 rtl/sched_pkg.sv | 23 ++
 rtl/sprite_hit_cmp.sv | 22 ++
 rtl/sprite_line_scheduler.sv | 169 ++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and widths for the per-scanline sprite scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam int DEF_N_OBJ   = 8;
    localparam int DEF_N_SLOTS = 4;
    localparam int LINE_W      = 10;
    localparam int ROW_W       = 7;
    // Widest object index needed for the largest table (64 objects).
    localparam int ID_MAX_W    = 6;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic [ROW_W-1:0]    row;
    } slot_t;

endpackage

// File: rtl/sprite_hit_cmp.sv
// Combinational test of whether one object covers the latched line,
// and which row of the object that line falls on.
module sprite_hit_cmp
    import sched_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [LINE_W-1:0] y_i,
    input  logic [ROW_W-1:0]  h_i,
    input  logic              valid_i,
    output logic              hit_o,
    output logic [ROW_W-1:0]  row_o
);

    // One extra bit so a line above the object's top shows up as a borrow.
    logic [LINE_W:0] diff;

    assign diff  = {1'b0, line_i} - {1'b0, y_i};
    assign hit_o = valid_i && !diff[LINE_W] &&
                   (diff < {{(LINE_W + 1 - ROW_W){1'b0}}, h_i});
    assign row_o = diff[ROW_W-1:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: during horizontal blank, walks the object
// table one entry per cycle and packs the first N_SLOTS hits (lowest index
// first) into render slots, committed together at the end of the pass.
// Optional build macro SCHED_OVF_CNT_EN adds ovf_lines, a saturating count
// of committed lines that had more hits than slots.
//
// state    | meaning
// S_IDLE   | waiting for hblank_start; outputs hold the last commit
// S_SCAN   | evaluating object idx against the latched line
// S_COMMIT | copying working slots and overflow to the outputs
module sprite_line_scheduler
    import sched_pkg::*;
#(
    parameter int N_OBJ   = DEF_N_OBJ,
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int ID_W    = $clog2(N_OBJ)
) (
    input  logic                      VGA_CLK,
    input  logic                      reset,
    input  logic                      hblank_start,
    input  logic [LINE_W-1:0]         next_line,
    input  logic [N_OBJ-1:0]          obj_valid,
    input  logic [N_OBJ*LINE_W-1:0]   obj_y,
    input  logic [N_OBJ*ROW_W-1:0]    obj_h,
    output logic [N_SLOTS-1:0]        slot_valid,
    output logic [N_SLOTS*ID_W-1:0]   slot_id,
    output logic [N_SLOTS*ROW_W-1:0]  slot_row,
    output logic                      sched_done,
    output logic                      overflow,
    output logic                      busy
`ifdef SCHED_OVF_CNT_EN
    ,
    output logic [15:0]               ovf_lines
`endif
);

    localparam int CNT_W = $clog2(N_SLOTS + 1);

    state_t             state_q;
    logic [ID_W-1:0]    idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LINE_W-1:0]  line_q;
    slot_t              work_q [N_SLOTS];
    slot_t              out_q  [N_SLOTS];
    logic               work_ovf_q;
    logic               ovf_q;
    logic               done_q;

    logic               sel_valid;
    logic [LINE_W-1:0]  sel_y;
    logic [ROW_W-1:0]   sel_h;
    logic               hit;
    logic [ROW_W-1:0]   row;

    // Route the object under evaluation to the single shared comparator.
    always_comb begin
        sel_valid = 1'b0;
        sel_y     = '0;
        sel_h     = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (idx_q == ID_W'(i)) begin
                sel_valid = obj_valid[i];
                sel_y     = obj_y[i*LINE_W +: LINE_W];
                sel_h     = obj_h[i*ROW_W +: ROW_W];
            end
        end
    end

    sprite_hit_cmp u_hit_cmp (
        .line_i  (line_q),
        .y_i     (sel_y),
        .h_i     (sel_h),
        .valid_i (sel_valid),
        .hit_o   (hit),
        .row_o   (row)
    );

    // Scan FSM; a new hblank_start in any state restarts the pass, which
    // also drops a pending commit so the outputs keep the previous line.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            line_q     <= '0;
            work_ovf_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < N_SLOTS; k++) begin
                work_q[k] <= '0;
                out_q[k]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (hblank_start) begin
                line_q     <= next_line;
                idx_q      <= '0;
                cnt_q      <= '0;
                work_ovf_q <= 1'b0;
                for (int k = 0; k < N_SLOTS; k++) begin
                    work_q[k] <= '0;
                end
                state_q    <= S_SCAN;
            end else begin
                case (state_q)
                    S_SCAN: begin
                        if (hit) begin
                            if (int'(cnt_q) < N_SLOTS) begin
                                for (int k = 0; k < N_SLOTS; k++) begin
                                    if (cnt_q == CNT_W'(k)) begin
                                        work_q[k] <= '{valid: 1'b1,
                                                       id:    ID_MAX_W'(idx_q),
                                                       row:   row};
                                    end
                                end
                                cnt_q <= cnt_q + 1'b1;
                            end else begin
                                work_ovf_q <= 1'b1;
                            end
                        end
                        if (int'(idx_q) == N_OBJ - 1) begin
                            state_q <= S_COMMIT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    S_COMMIT: begin
                        for (int k = 0; k < N_SLOTS; k++) begin
                            out_q[k] <= work_q[k];
                        end
                        ovf_q   <= work_ovf_q;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SCHED_OVF_CNT_EN
    // Saturating count of committed lines that dropped objects.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            ovf_lines <= '0;
        end else if (state_q == S_COMMIT && !hblank_start && work_ovf_q &&
                     ovf_lines != 16'hFFFF) begin
            ovf_lines <= ovf_lines + 16'd1;
        end
    end
`endif

    // Flatten committed slot records onto the compositor-facing buses.
    always_comb begin
        slot_valid = '0;
        slot_id    = '0;
        slot_row   = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            slot_valid[k]                = out_q[k].valid;
            slot_id[k*ID_W +: ID_W]      = ID_W'(out_q[k].id);
            slot_row[k*ROW_W +: ROW_W]   = out_q[k].row;
        end
    end

    assign sched_done = done_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: each launched pass pushes the
// expected slot table, computed directly from the object list, and a monitor
// compares it whenever sched_done is seen.
module tb_sprite_line_scheduler;

    localparam int N_OBJ   = 8;
    localparam int N_SLOTS = 4;
    localparam int ID_W    = 3;

    logic                    VGA_CLK;
    logic                    reset;
    logic                    hblank_start;
    logic [9:0]              next_line;
    logic [N_OBJ-1:0]        obj_valid;
    logic [N_OBJ*10-1:0]     obj_y;
    logic [N_OBJ*7-1:0]      obj_h;
    logic [N_SLOTS-1:0]      slot_valid;
    logic [N_SLOTS*ID_W-1:0] slot_id;
    logic [N_SLOTS*7-1:0]    slot_row;
    logic                    sched_done;
    logic                    overflow;
    logic                    busy;
`ifdef SCHED_OVF_CNT_EN
    logic [15:0]             ovf_lines;
    int                      exp_ovf_lines = 0;
`endif

    logic [9:0]              ty [N_OBJ];
    logic [6:0]              th [N_OBJ];
    logic [N_OBJ-1:0]        tv;

    typedef struct {
        logic [N_SLOTS-1:0]      v;
        logic [N_SLOTS*ID_W-1:0] id;
        logic [N_SLOTS*7-1:0]    row;
        logic                    ovf;
        int                      done_cyc;
    } exp_t;

    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    sprite_line_scheduler #(.N_OBJ(N_OBJ), .N_SLOTS(N_SLOTS), .ID_W(ID_W)) dut (
        .VGA_CLK      (VGA_CLK),
        .reset        (reset),
        .hblank_start (hblank_start),
        .next_line    (next_line),
        .obj_valid    (obj_valid),
        .obj_y        (obj_y),
        .obj_h        (obj_h),
        .slot_valid   (slot_valid),
        .slot_id      (slot_id),
        .slot_row     (slot_row),
        .sched_done   (sched_done),
        .overflow     (overflow),
        .busy         (busy)
`ifdef SCHED_OVF_CNT_EN
        ,
        .ovf_lines    (ovf_lines)
`endif
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    always @(posedge VGA_CLK) cyc <= cyc + 1;

    always_comb begin
        obj_y     = '0;
        obj_h     = '0;
        obj_valid = tv;
        for (int i = 0; i < N_OBJ; i++) begin
            obj_y[i*10 +: 10] = ty[i];
            obj_h[i*7 +: 7]   = th[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scan the table in index order, first N_SLOTS hits fill slots.
    function automatic exp_t model(input int line);
        exp_t e;
        int   n = 0;
        e.v = '0; e.id = '0; e.row = '0; e.ovf = 1'b0; e.done_cyc = 0;
        for (int i = 0; i < N_OBJ; i++) begin
            int d = line - int'(ty[i]);
            if (tv[i] && d >= 0 && d < int'(th[i])) begin
                if (n < N_SLOTS) begin
                    e.v[n]              = 1'b1;
                    e.id[n*ID_W +: ID_W] = ID_W'(i);
                    e.row[n*7 +: 7]      = 7'(d);
                    n++;
                end else begin
                    e.ovf = 1'b1;
                end
            end
        end
        return e;
    endfunction

    always @(negedge VGA_CLK) begin
        if (!reset && sched_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("slot_valid", slot_valid, e.v);
                check("slot_id", slot_id, e.id);
                check("slot_row", slot_row, e.row);
                check("overflow", overflow, e.ovf);
`ifdef SCHED_OVF_CNT_EN
                if (e.ovf) exp_ovf_lines++;
                check("ovf_lines", ovf_lines, exp_ovf_lines);
`endif
            end
        end
    end

    task automatic clear_objs();
        tv = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            ty[i] = '0;
            th[i] = '0;
        end
    endtask

    task automatic set_obj(input int i, input int y, input int h);
        tv[i] = 1'b1;
        ty[i] = 10'(y);
        th[i] = 7'(h);
    endtask

    // Pulse hblank_start for one edge (E0) and queue the expected result.
    task automatic launch(input int line);
        exp_t e;
        next_line    = 10'(line);
        hblank_start = 1'b1;
        @(posedge VGA_CLK);
        #1;
        hblank_start = 1'b0;
        e = model(line);
        e.done_cyc = cyc + N_OBJ + 1;
        sb.push_back(e);
        check("busy_start", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge VGA_CLK);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
        @(posedge VGA_CLK);
        #1;
        check("busy_idle", busy, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_slot_valid", slot_valid, 0);
        check("rst_slot_id", slot_id, 0);
        check("rst_slot_row", slot_row, 0);
        check("rst_sched_done", sched_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        logic [N_SLOTS-1:0] held_v;
        int base;
        reset        = 1'b1;
        hblank_start = 1'b0;
        next_line    = '0;
        clear_objs();
        repeat (3) @(posedge VGA_CLK);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge VGA_CLK);
        #1;

        // Two overlapping objects on line 115.
        clear_objs();
        set_obj(2, 100, 24);
        set_obj(5, 110, 24);
        launch(115);
        wait_idle();
        check("two_hit_valid", slot_valid, 4'b0011);
        check("two_hit_id", slot_id, {3'd0, 3'd0, 3'd5, 3'd2});
        check("two_hit_row", slot_row, {7'd0, 7'd0, 7'd5, 7'd15});

        // Boundaries of a single object.
        clear_objs();
        set_obj(0, 100, 24);
        launch(123);
        wait_idle();
        check("last_row_valid", slot_valid, 4'b0001);
        check("last_row_row", slot_row, {21'd0, 7'd23});
        launch(124);
        wait_idle();
        check("past_bottom", slot_valid, 4'b0000);
        launch(99);
        wait_idle();
        check("above_top", slot_valid, 4'b0000);
        th[0] = 7'd0;
        launch(100);
        wait_idle();
        check("zero_height", slot_valid, 4'b0000);

        // More hits than slots.
        clear_objs();
        for (int i = 0; i < 6; i++) set_obj(i, 0, 16);
        launch(5);
        wait_idle();
        check("ovf_flag", overflow, 1);
        check("ovf_ids", slot_id, {3'd3, 3'd2, 3'd1, 3'd0});
        launch(6);
        wait_idle();

        // Disabled object keeps its geometry but must be skipped.
        clear_objs();
        for (int i = 0; i < 5; i++) set_obj(i, 50, 10);
        tv[3] = 1'b0;
        launch(55);
        wait_idle();
        check("skip_invalid_ids", slot_id, {3'd4, 3'd2, 3'd1, 3'd0});
        check("skip_invalid_ovf", overflow, 0);

        // Restart at E0+4 with line 200; earlier pass must never commit.
        held_v = slot_valid;
        clear_objs();
        set_obj(1, 190, 20);
        set_obj(6, 195, 10);
        next_line    = 10'd100;
        hblank_start = 1'b1;
        @(posedge VGA_CLK);
        #1;
        hblank_start = 1'b0;
        repeat (3) @(posedge VGA_CLK);
        #1;
        launch(200);
        repeat (5) @(posedge VGA_CLK);
        #1;
        check("restart_hold", slot_valid, held_v);
        wait_idle();
        check("restart_valid", slot_valid, 4'b0011);
        check("restart_id", slot_id, {3'd0, 3'd0, 3'd6, 3'd1});
        check("restart_row", slot_row, {7'd0, 7'd0, 7'd5, 7'd10});

        // Reset at E0+3 in the middle of a scan.
        launch(200);
        repeat (2) @(posedge VGA_CLK);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs();
`ifdef SCHED_OVF_CNT_EN
        check("rst_ovf_lines", ovf_lines, 0);
        exp_ovf_lines = 0;
`endif
        @(posedge VGA_CLK);
        #1;
        reset = 1'b0;
        launch(205);
        wait_idle();

        // Randomized tables clustered around the target line.
        for (int t = 0; t < 30; t++) begin
            base = $urandom_range(0, 479);
            clear_objs();
            for (int i = 0; i < N_OBJ; i++) begin
                int y = base - int'($urandom_range(0, 60)) + 5;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                tv[i] = ($urandom_range(0, 3) != 0);
                ty[i] = 10'(y);
                th[i] = 7'($urandom_range(0, 127));
            end
            launch(base);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
